mac_rx_frame_ctrl: RTL and testbench
====================================

// Module: mac_rx_frame_ctrl
// PURPOSE
//  Frame sequencer between PCS decode and mac_rx. Tracks IDLE/START/DATA/TERM control
//  stream, checks preamble/SFD, counts frame bytes, enforces runt/oversize/framing rules.
//  Drives mac_rx with registered stream + cancel; reports per-frame status to MAC CSRs.
// PARAMETERS
//  DATA_W   16    datapath width, bits; multiple of 16, max 64
//  KEEP_W   DATA_W/8  byte lanes
//  MIN_LEN  64    min frame bytes after SFD (incl. FCS)
//  MAX_LEN  1522  max frame bytes after SFD (VLAN-tagged max)
//  LEN_W    16    byte-counter width; must hold MAX_LEN+8+KEEP_W
// PORTS
//  clk          in   1       clock
//  nreset       in   1       async active-low reset
//  valid_i      in   1       PCS beat valid; low = stall, no state advance
//  data_i       in   DATA_W  PCS data, byte 0 in [7:0]
//  ctrl_v_i     in   1       beat carries control (idle/start/term)
//  idle_i       in   1       idle control
//  start_i      in   1       start control, lane 0
//  term_i       in   1       terminate control
//  term_keep_i  in   KEEP_W  data bytes valid in term beat (thermometer from lane 0)
//  valid_o      out  1       beat to mac_rx
//  data_o       out  DATA_W  data to mac_rx
//  ctrl_v_o,start_o,term_o  out 1 each  control forwarded to mac_rx
//  term_keep_o  out  KEEP_W  forwarded keep
//  cancel_o     out  1       1-cycle pulse: abort current frame in mac_rx
//  done_o       out  1       1-cycle pulse: frame ended (good or bad)
//  err_o        out  3       {framing, oversize, runt}; valid with done_o
//  len_o        out  LEN_W   bytes after SFD; valid with done_o
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, len=0. Async assert, sync deassert (external).
//  - Latency: every output registered, 1 cycle after accepted input beat (valid_i=1).
//  - valid_i=0: FSM/counter hold, valid_o=0, cancel_o/done_o=0.
//  - FSM IDLE: start_i -> PRE (beat is byte 0..KEEP_W-1 of preamble); anything else stays.
//    Data beat without start -> stays IDLE, dropped, not forwarded.
//  - PRE: 8 bytes; bytes 0..6 must = PRE_BYTE 8'hAA, byte 7 = SFD_BYTE 8'hAB.
//    Mismatch -> cancel_o, done_o, err[2]=1, -> DROP. 8th byte seen -> DATA.
//  - DATA: len += KEEP_W per data beat; term beat adds popcount(term_keep_i).
//    len > MAX_LEN -> cancel_o, done_o, err[1], -> DROP (same cycle overflow seen).
//    term_i -> done_o; len < MIN_LEN -> err[0]+cancel_o; -> IDLE.
//    idle_i before term -> cancel_o, done_o, err[2], -> IDLE.
//    start_i in DATA/PRE -> cancel_o, done_o, err[2] for old frame; new frame enters PRE.
//  - DROP: forward nothing; term_i or idle_i -> IDLE; start_i -> PRE (new frame).
//  - Forwarding: valid_o=1 only in PRE/DATA and on beat leaving them; DROP/IDLE suppressed.
//  - len saturates at 2^LEN_W-1; cleared on entry to PRE.
//  - cancel_o and done_o never pulse twice per frame; done_o asserted with final cancel_o.
// CONFIGURATION
//  MAC_RX_FRAME_STATS_EN defined: adds outputs stat_good_o, stat_bad_o (32b each),
//   incr on done_o by err_o==0 / !=0, saturating, reset 0. Undefined: ports/logic absent.
// STRUCTURE
//  Package mac_rx_pkg: PRE_BYTE, SFD_BYTE, err bit index localparams,
//   typedef enum logic [1:0] {IDLE,PRE,DATA,DROP} rx_fsm_e.
//  Sub-module mac_rx_len_cnt: keep popcount + saturating byte counter + bound compare.
// TESTING
//  1 idle x3, start+pre AA..AB, 64 bytes, term keep=2'b00 -> done_o, err=0, len=64, no cancel
//  2 pre byte 7 = 8'hAA -> cancel_o+done_o 1 cycle after beat 4, err=3'b100, rest dropped
//  3 1524-byte payload -> cancel_o at beat with len 1524 > 1522, err=3'b010, DROP till term
//  4 60-byte frame, term keep=2'b01 -> len=61, err=3'b001, cancel_o with done_o
//  5 valid_i=0 for 3 cycles mid-frame -> len/FSM frozen, valid_o=0; final len unchanged
//  6 start_i mid-DATA -> cancel_o/err=3'b100 old frame, new frame completes with err=0
//  7 nreset low in DATA -> outputs 0 immediately; next frame after release good

Source files
------------

// File: rtl/mac_rx_pkg.sv
// Shared constants and state encoding for the receive frame sequencer.
package mac_rx_pkg;

  localparam logic [7:0] PRE_BYTE = 8'hAA;
  localparam logic [7:0] SFD_BYTE = 8'hAB;
  localparam int         PRE_LEN  = 8;

  localparam int ERR_RUNT    = 0;
  localparam int ERR_OVER    = 1;
  localparam int ERR_FRAMING = 2;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } rx_fsm_e;

endpackage

// File: rtl/mac_rx_len_cnt.sv
// Frame byte counter: keep popcount, saturating accumulate, runt/oversize compare
// on the post-increment value so bounds are seen on the beat that crosses them.
module mac_rx_len_cnt #(
  parameter int KEEP_W  = 2,
  parameter int LEN_W   = 16,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [KEEP_W-1:0] keep_i,
  output logic [LEN_W-1:0]  len_o,
  output logic [LEN_W-1:0]  len_nxt_o,
  output logic              over_o,
  output logic              runt_o
);

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] pcnt;
  logic [LEN_W:0]   sum;

  always_comb begin
    pcnt = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      pcnt = pcnt + LEN_W'(keep_i[i]);
    end
  end

  assign sum       = {1'b0, len_q} + {1'b0, pcnt};
  assign len_nxt_o = sum[LEN_W] ? '1 : sum[LEN_W-1:0];
  assign over_o    = len_nxt_o > LEN_W'(MAX_LEN);
  assign runt_o    = len_nxt_o < LEN_W'(MIN_LEN);
  assign len_o     = len_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      len_q <= '0;
    end else if (clr_i) begin
      len_q <= '0;
    end else if (add_i) begin
      len_q <= len_nxt_o;
    end
  end

endmodule

// File: rtl/mac_rx_frame_ctrl.sv
// Receive frame sequencer between PCS decode and mac_rx: preamble/SFD check, length
// bounds, cancel/done/status. Optional per-frame counters under MAC_RX_FRAME_STATS_EN.
//
//   state | meaning
//   IDLE  | between frames, data beats dropped
//   PRE   | collecting preamble bytes, forwarding
//   DATA  | counting post-SFD bytes, forwarding
//   DROP  | frame aborted, discard until term/idle/start
module mac_rx_frame_ctrl
  import mac_rx_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int KEEP_W  = DATA_W / 8,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522,
  parameter int LEN_W   = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ctrl_v_i,
  input  logic              idle_i,
  input  logic              start_i,
  input  logic              term_i,
  input  logic [KEEP_W-1:0] term_keep_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              ctrl_v_o,
  output logic              start_o,
  output logic              term_o,
  output logic [KEEP_W-1:0] term_keep_o,
  output logic              cancel_o,
  output logic              done_o,
`ifdef MAC_RX_FRAME_STATS_EN
  output logic [31:0]       stat_good_o,
  output logic [31:0]       stat_bad_o,
`endif
  output logic [2:0]        err_o,
  output logic [LEN_W-1:0]  len_o
);

  rx_fsm_e          state_q, state_d, new_st;
  logic [3:0]       pre_cnt_q, pre_cnt_d, pre_base;
  logic             st, tm, id, dat;
  logic             pre_ok, pre_last;
  logic [4:0]       idx;
  logic             fwd, begin_frame, frame_abort;
  logic             done_d, cancel_d;
  logic [2:0]       err_d;
  logic [LEN_W-1:0] len_rep;
  logic             cnt_clr, cnt_add;
  logic [LEN_W-1:0] cnt_len, cnt_nxt;
  logic             cnt_over, cnt_runt;

  assign st  = ctrl_v_i & start_i;
  assign tm  = ctrl_v_i & term_i & ~start_i;
  assign id  = ctrl_v_i & idle_i & ~start_i & ~term_i;
  assign dat = ~ctrl_v_i;

  // A start beat always carries preamble bytes 0..KEEP_W-1, whatever the state.
  assign pre_base = st ? 4'd0 : pre_cnt_q;

  always_comb begin
    pre_ok = 1'b1;
    idx    = '0;
    for (int l = 0; l < KEEP_W; l++) begin
      idx = 5'(pre_base) + 5'(l);
      if (idx < 5'(PRE_LEN - 1)) begin
        if (data_i[8*l +: 8] != PRE_BYTE) pre_ok = 1'b0;
      end else if (idx == 5'(PRE_LEN - 1)) begin
        if (data_i[8*l +: 8] != SFD_BYTE) pre_ok = 1'b0;
      end
    end
    pre_last = (5'(pre_base) + 5'(KEEP_W)) >= 5'(PRE_LEN);
    new_st   = !pre_ok ? DROP : (pre_last ? DATA : PRE);
  end

  mac_rx_len_cnt #(
    .KEEP_W (KEEP_W),
    .LEN_W  (LEN_W),
    .MIN_LEN(MIN_LEN),
    .MAX_LEN(MAX_LEN)
  ) u_len_cnt (
    .clk      (clk),
    .nreset   (nreset),
    .clr_i    (cnt_clr),
    .add_i    (cnt_add),
    .keep_i   (tm ? term_keep_i : {KEEP_W{1'b1}}),
    .len_o    (cnt_len),
    .len_nxt_o(cnt_nxt),
    .over_o   (cnt_over),
    .runt_o   (cnt_runt)
  );

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    fwd         = 1'b0;
    begin_frame = 1'b0;
    frame_abort = 1'b0;
    done_d      = 1'b0;
    cancel_d    = 1'b0;
    err_d       = '0;
    len_rep     = cnt_len;
    cnt_clr     = 1'b0;
    cnt_add     = 1'b0;
    if (valid_i) begin
      unique case (state_q)
        IDLE, DROP: begin
          if (st) begin
            fwd         = 1'b1;
            begin_frame = 1'b1;
            frame_abort = ~pre_ok;
            len_rep     = '0;
          end else if ((state_q == DROP) && (tm || id)) begin
            state_d = IDLE;
          end
        end
        PRE: begin
          fwd = 1'b1;
          if (st) begin
            frame_abort = 1'b1;
            begin_frame = 1'b1;
          end else if (tm || id) begin
            frame_abort = 1'b1;
            state_d     = IDLE;
          end else if (dat) begin
            if (!pre_ok) begin
              frame_abort = 1'b1;
              state_d     = DROP;
            end else if (pre_last) begin
              state_d = DATA;
            end else begin
              pre_cnt_d = pre_cnt_q + 4'(KEEP_W);
            end
          end
        end
        DATA: begin
          fwd = 1'b1;
          if (st) begin
            frame_abort = 1'b1;
            begin_frame = 1'b1;
          end else if (id) begin
            frame_abort = 1'b1;
            state_d     = IDLE;
          end else if (tm) begin
            cnt_add          = 1'b1;
            done_d           = 1'b1;
            cancel_d         = cnt_over | cnt_runt;
            err_d[ERR_OVER]  = cnt_over;
            err_d[ERR_RUNT]  = cnt_runt;
            len_rep          = cnt_nxt;
            state_d          = IDLE;
          end else if (dat) begin
            cnt_add = 1'b1;
            if (cnt_over) begin
              done_d          = 1'b1;
              cancel_d        = 1'b1;
              err_d[ERR_OVER] = 1'b1;
              len_rep         = cnt_nxt;
              state_d         = DROP;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // A restart reports only the old frame; a bad preamble on the new start beat
    // sends it straight to DROP without a second pulse.
    if (begin_frame) begin
      cnt_clr   = 1'b1;
      pre_cnt_d = 4'(KEEP_W);
      state_d   = new_st;
    end
    if (frame_abort) begin
      done_d             = 1'b1;
      cancel_d           = 1'b1;
      err_d              = '0;
      err_d[ERR_FRAMING] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      pre_cnt_q   <= '0;
      valid_o     <= 1'b0;
      data_o      <= '0;
      ctrl_v_o    <= 1'b0;
      start_o     <= 1'b0;
      term_o      <= 1'b0;
      term_keep_o <= '0;
      cancel_o    <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= '0;
      len_o       <= '0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      valid_o     <= valid_i & fwd;
      data_o      <= (valid_i & fwd) ? data_i : '0;
      ctrl_v_o    <= valid_i & fwd & ctrl_v_i;
      start_o     <= valid_i & fwd & ctrl_v_i & start_i;
      term_o      <= valid_i & fwd & ctrl_v_i & term_i;
      term_keep_o <= (valid_i & fwd) ? term_keep_i : '0;
      cancel_o    <= cancel_d;
      done_o      <= done_d;
      err_o       <= err_d;
      if (done_d) len_o <= len_rep;
    end
  end

`ifdef MAC_RX_FRAME_STATS_EN
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      stat_good_o <= '0;
      stat_bad_o  <= '0;
    end else if (done_d) begin
      if (err_d == 3'b000) begin
        if (stat_good_o != '1) stat_good_o <= stat_good_o + 32'd1;
      end else begin
        if (stat_bad_o != '1) stat_bad_o <= stat_bad_o + 32'd1;
      end
    end
  end
`else
  // Statistics counters not built.
`endif

endmodule

// File: tb/tb_mac_rx_frame_ctrl.sv
// Scoreboard bench for mac_rx_frame_ctrl: expected done records queued at stimulus,
// popped by a negedge monitor.
module tb_mac_rx_frame_ctrl;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        valid_i = 1'b0;
  logic [15:0] data_i = '0;
  logic        ctrl_v_i = 1'b0, idle_i = 1'b0, start_i = 1'b0, term_i = 1'b0;
  logic [1:0]  term_keep_i = '0;
  logic        valid_o, ctrl_v_o, start_o, term_o, cancel_o, done_o;
  logic [15:0] data_o;
  logic [1:0]  term_keep_o;
  logic [2:0]  err_o;
  logic [15:0] len_o;
`ifdef MAC_RX_FRAME_STATS_EN
  logic [31:0] stat_good_o, stat_bad_o;
`endif

  typedef struct {
    logic [2:0]  err;
    logic [15:0] len;
    logic        cancel;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   fwd_cnt = 0;

  always #5 clk = ~clk;

  mac_rx_frame_ctrl dut (
    .clk        (clk),
    .nreset     (nreset),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .ctrl_v_i   (ctrl_v_i),
    .idle_i     (idle_i),
    .start_i    (start_i),
    .term_i     (term_i),
    .term_keep_i(term_keep_i),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .ctrl_v_o   (ctrl_v_o),
    .start_o    (start_o),
    .term_o     (term_o),
    .term_keep_o(term_keep_o),
    .cancel_o   (cancel_o),
    .done_o     (done_o),
`ifdef MAC_RX_FRAME_STATS_EN
    .stat_good_o(stat_good_o),
    .stat_bad_o (stat_bad_o),
`endif
    .err_o      (err_o),
    .len_o      (len_o)
  );

  always @(negedge clk) begin
    if (nreset) begin
      if (valid_o) fwd_cnt++;
      if (cancel_o) begin
        vectors++;
        if (!done_o) begin
          miscompares++;
          $display("FAIL cancel_without_done got done=%b required 1", done_o);
        end
      end
      if (done_o) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done err=%b len=%0d required no done", err_o, len_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if ({err_o, len_o, cancel_o} !== {e.err, e.len, e.cancel}) begin
            miscompares++;
            $display("FAIL done_status got err=%b len=%0d cancel=%b required err=%b len=%0d cancel=%b",
                     err_o, len_o, cancel_o, e.err, e.len, e.cancel);
          end
        end
      end
    end
  end

  task automatic beat(input logic v, input logic c, input logic id, input logic st,
                      input logic tm, input logic [1:0] keep, input logic [15:0] d);
    valid_i = v; ctrl_v_i = c; idle_i = id; start_i = st; term_i = tm;
    term_keep_i = keep; data_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_idle(input int n);
    repeat (n) beat(1, 1, 1, 0, 0, 2'b00, 16'h0707);
  endtask

  task automatic send_data(input int n);
    repeat (n) beat(1, 0, 0, 0, 0, 2'b00, 16'($urandom));
  endtask

  task automatic send_pre(input logic [7:0] b7);
    beat(1, 1, 0, 1, 0, 2'b00, 16'hAAAA);
    beat(1, 0, 0, 0, 0, 2'b00, 16'hAAAA);
    beat(1, 0, 0, 0, 0, 2'b00, 16'hAAAA);
    beat(1, 0, 0, 0, 0, 2'b00, {b7, 8'hAA});
  endtask

  task automatic send_term(input logic [1:0] keep);
    beat(1, 1, 0, 0, 1, keep, 16'($urandom));
  endtask

  task automatic push_exp(input logic [2:0] err, input logic [15:0] len, input logic cancel);
    exp_t e;
    e.err = err; e.len = len; e.cancel = cancel;
    exp_q.push_back(e);
  endtask

  task automatic check_fwd(input string name, input int required);
    vectors++;
    if (fwd_cnt !== required) begin
      miscompares++;
      $display("FAIL %s forwarded=%0d required=%0d", name, fwd_cnt, required);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({valid_o, cancel_o, done_o, start_o, term_o} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b required 00000", {valid_o, cancel_o, done_o, start_o, term_o});
    end
    vectors++;
    if ({err_o, len_o, data_o} !== 35'b0) begin
      miscompares++;
      $display("FAIL reset_status got err=%b len=%0d data=%h required 0", err_o, len_o, data_o);
    end
  endtask

  task automatic test_good();
    send_idle(3);
    fwd_cnt = 0;
    beat(1, 1, 0, 1, 0, 2'b00, 16'hAAAA);
    vectors++;
    if ({valid_o, start_o, data_o} !== {2'b11, 16'hAAAA}) begin
      miscompares++;
      $display("FAIL good_start_fwd got v=%b s=%b d=%h required v=1 s=1 d=aaaa", valid_o, start_o, data_o);
    end
    beat(1, 0, 0, 0, 0, 2'b00, 16'hAAAA);
    beat(1, 0, 0, 0, 0, 2'b00, 16'hAAAA);
    beat(1, 0, 0, 0, 0, 2'b00, 16'hABAA);
    send_data(32);
    push_exp(3'b000, 16'd64, 1'b0);
    send_term(2'b00);
    send_idle(2);
    check_fwd("good_fwd", 37);
  endtask

  task automatic test_bad_sfd();
    fwd_cnt = 0;
    push_exp(3'b100, 16'd0, 1'b1);
    send_pre(8'hAA);
    vectors++;
    if ({done_o, cancel_o} !== 2'b11) begin
      miscompares++;
      $display("FAIL sfd_abort_timing got done=%b cancel=%b required 1 1", done_o, cancel_o);
    end
    send_data(10);
    send_term(2'b11);
    send_idle(2);
    check_fwd("sfd_fwd", 4);
  endtask

  task automatic test_oversize();
    fwd_cnt = 0;
    send_pre(8'hAB);
    send_data(761);
    push_exp(3'b010, 16'd1524, 1'b1);
    send_data(1);
    send_data(5);
    send_term(2'b11);
    send_idle(2);
    check_fwd("over_fwd", 766);
  endtask

  task automatic test_runt();
    fwd_cnt = 0;
    send_pre(8'hAB);
    send_data(30);
    push_exp(3'b001, 16'd61, 1'b1);
    send_term(2'b01);
    vectors++;
    if ({term_o, term_keep_o} !== 3'b101) begin
      miscompares++;
      $display("FAIL runt_term_fwd got term=%b keep=%b required term=1 keep=01", term_o, term_keep_o);
    end
    send_idle(2);
    check_fwd("runt_fwd", 35);
  endtask

  task automatic test_stall();
    fwd_cnt = 0;
    send_pre(8'hAB);
    send_data(20);
    for (int i = 0; i < 3; i++) begin
      beat(0, 0, 0, 0, 0, 2'b00, 16'hDEAD);
      vectors++;
      if ({valid_o, done_o, cancel_o} !== 3'b000) begin
        miscompares++;
        $display("FAIL stall_quiet got v=%b d=%b c=%b required 000", valid_o, done_o, cancel_o);
      end
    end
    send_data(12);
    push_exp(3'b000, 16'd66, 1'b0);
    send_term(2'b11);
    send_idle(2);
    check_fwd("stall_fwd", 37);
  endtask

  task automatic test_restart();
    fwd_cnt = 0;
    send_pre(8'hAB);
    send_data(10);
    push_exp(3'b100, 16'd20, 1'b1);
    push_exp(3'b000, 16'd64, 1'b0);
    send_pre(8'hAB);
    send_data(32);
    send_term(2'b00);
    send_idle(2);
    check_fwd("restart_fwd", 51);
  endtask

  task automatic test_async_reset();
    send_pre(8'hAB);
    send_data(10);
    #2;
    nreset = 1'b0;
    #1;
    vectors++;
    if ({valid_o, done_o, cancel_o, start_o, term_o, err_o, len_o, data_o} !== 40'b0) begin
      miscompares++;
      $display("FAIL async_reset got v=%b d=%b c=%b err=%b len=%0d data=%h required 0",
               valid_o, done_o, cancel_o, err_o, len_o, data_o);
    end
    valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    fwd_cnt = 0;
    send_idle(2);
    push_exp(3'b000, 16'd64, 1'b0);
    send_pre(8'hAB);
    send_data(32);
    send_term(2'b00);
    send_idle(2);
    check_fwd("post_reset_fwd", 37);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    nreset = 1'b1;
    test_good();
    test_bad_sfd();
    test_oversize();
    test_runt();
    test_stall();
    test_restart();
    test_async_reset();
    send_idle(3);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_done outstanding=%0d required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
